// File: rtl/da_fir_pkg.sv
// da_fir_pkg: shared state encoding and width/rounding/saturation helpers for the DA FIR atom
package da_fir_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINAL, HOLD} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + clog2(ntaps) + 1;
  endfunction
  function automatic longint round_addend(input int frac, input bit rnd);
    return (rnd && frac > 0) ? (longint'(1) <<< (frac - 1)) : longint'(0);
  endfunction
  function automatic longint sat_wrap(input longint v, input int ow, input bit sat);
    longint hi = (longint'(1) <<< (ow - 1)) - 1;
    longint lo = -hi - 1;
    return !sat ? v : v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/da_partial_lut.sv
// da_partial_lut: sums the coefficients of the taps whose current sample bit is set
module da_partial_lut #(
  parameter int NTAPS = 2,
  parameter int CW = 8,
  parameter int PW = 10,
  parameter logic [NTAPS*CW-1:0] COEFS = '0
) (
  input  logic [NTAPS-1:0]       sel,
  output logic signed [PW-1:0]   p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < NTAPS; i++)
      if (sel[i]) p = p + PW'($signed(COEFS[i*CW +: CW]));
  end
endmodule

// File: rtl/da_fir_atom.sv
// da_fir_atom: bit-serial distributed-arithmetic MAC with valid/ready sample and result handshakes
module da_fir_atom import da_fir_pkg::*; #(
  parameter int DW = 8,
  parameter int NTAPS = 2,
  parameter int CW = 8,
  parameter logic [NTAPS*CW-1:0] COEFS = '0,
  parameter int SIGNED_IN = 1,
  parameter int FRAC = 7,
  parameter int OW = 8,
  parameter int ROUND = 1,
  parameter int SAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NTAPS*DW-1:0]   in_samples,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_sample,
  output logic                  busy
);
  localparam int AW = acc_width(DW, CW, NTAPS);
  localparam int PW = CW + clog2(NTAPS) + 1;
  localparam int KW = clog2(DW + 1);
  state_t state;
  logic [NTAPS*DW-1:0] xs;
  logic [KW-1:0] k;
  logic signed [AW-1:0] acc, term, rnd_v, shf;
  logic signed [PW-1:0] p;
  logic [NTAPS-1:0] sel;
  logic last, accept;
  for (genvar i = 0; i < NTAPS; i++) begin : g_sel
    assign sel[i] = xs[i*DW + int'(k)];
  end
  da_partial_lut #(.NTAPS(NTAPS), .CW(CW), .PW(PW), .COEFS(COEFS)) u_lut (
    .sel(sel),
    .p(p)
  );
  assign last = k == KW'(DW - 1);
  assign term = AW'(p) <<< k;
  assign rnd_v = acc + AW'(round_addend(FRAC, ROUND != 0));
  assign shf = rnd_v >>> FRAC;
  assign in_ready = state == IDLE || (state == HOLD && out_ready);
  assign accept = in_valid && in_ready;
  assign busy = state == RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      xs <= '0;
      acc <= '0;
      k <= '0;
      out_valid <= 1'b0;
      out_sample <= '0;
    end else begin
      if (accept) begin
        xs <= in_samples;
        acc <= '0;
        k <= '0;
        state <= RUN;
      end else if (state == RUN && step_en) begin
        // the sign bit of a two's-complement sample carries negative weight
        acc <= (SIGNED_IN != 0 && last) ? acc - term : acc + term;
        k <= k + 1'b1;
        state <= last ? FINAL : RUN;
      end else if (state == FINAL) begin
        out_sample <= OW'(sat_wrap(longint'(shf), OW, SAT != 0));
        state <= HOLD;
      end else if (state == HOLD && out_ready) begin
        state <= IDLE;
      end
      out_valid <= state == FINAL || (state == HOLD && !out_ready);
    end
  end
endmodule

// File: tb/tb_da_fir_atom.sv
// tb_da_fir_atom: six parameter variants driven in lockstep, checked against a direct-sum model
module tb_da_fir_atom;
  typedef logic [5:0][7:0] exp_t;
  logic clk, reset, step_en, in_valid, out_ready;
  logic [15:0] in_samples;
  logic ov[6], ir[6], bz[6];
  logic [7:0] os[6];
  exp_t sb[$];
  int checks = 0, errors = 0;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    da_fir_atom #(
      .DW(8), .NTAPS(2), .CW(8),
      .COEFS(g < 2 ? 16'h2040 : g < 4 ? 16'h7F7F : 16'h0001),
      .SIGNED_IN(g != 1 ? 1 : 0), .FRAC(7), .OW(8),
      .ROUND(g != 5 ? 1 : 0), .SAT(g != 3 ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(reset), .step_en(step_en),
      .in_valid(in_valid), .in_ready(ir[g]), .in_samples(in_samples),
      .out_valid(ov[g]), .out_ready(out_ready), .out_sample(os[g]), .busy(bz[g])
    );
  end

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] x0, input logic [7:0] x1, input int c0,
                                       input int c1, input bit sgn, input bit rnd, input bit sat);
    longint v0 = sgn ? longint'($signed(x0)) : longint'(x0);
    longint v1 = sgn ? longint'($signed(x1)) : longint'(x1);
    longint a = c0 * v0 + c1 * v1 + (rnd ? 64 : 0);
    a = a >>> 7;
    if (sat) a = a > 127 ? 127 : a < -128 ? -128 : a;
    return a[7:0];
  endfunction

  function automatic exp_t expect_all(input logic [7:0] x0, input logic [7:0] x1);
    exp_t e;
    e[0] = model(x0, x1, 64, 32, 1, 1, 1);
    e[1] = model(x0, x1, 64, 32, 0, 1, 1);
    e[2] = model(x0, x1, 127, 127, 1, 1, 1);
    e[3] = model(x0, x1, 127, 127, 1, 1, 0);
    e[4] = model(x0, x1, 1, 0, 1, 1, 1);
    e[5] = model(x0, x1, 1, 0, 1, 0, 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept_txn(input string tag, input logic [7:0] x0, input logic [7:0] x1);
    in_valid = 1;
    in_samples = {x1, x0};
    sb.push_back(expect_all(x0, x1));
    #1;
    chk({tag, "_in_ready"}, 32'(ir[0]), 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_out(input string tag, input bit noise, input bit sparse, output int cyc, output int steps);
    cyc = 1;
    steps = 0;
    while (!ov[0] && cyc < 400) begin
      if (noise) begin
        in_valid = cyc >= 2 && cyc < 6;
        in_samples = 16'hA5A5;
      end
      if (sparse) step_en = (cyc % 10) == 0;
      if (step_en && bz[0]) steps++;
      @(negedge clk);
      cyc++;
    end
    step_en = 1;
    in_valid = 0;
    chk({tag, "_timeout"}, 32'(ov[0]), 1);
  endtask

  task automatic compare_out(input string tag, output exp_t e);
    e = '0;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("%s_out%0d", tag, i), 32'(os[i]), 32'(e[i]));
        chk($sformatf("%s_valid%0d", tag, i), 32'(ov[i]), 1);
      end
    end
  endtask

  task automatic txn(input string tag, input logic [7:0] x0, input logic [7:0] x1, input bit noise);
    exp_t e;
    int cyc, steps;
    accept_txn(tag, x0, x1);
    wait_out(tag, noise, 0, cyc, steps);
    chk({tag, "_latency"}, 32'(cyc), 10);
    compare_out(tag, e);
    @(negedge clk);
    chk({tag, "_drop"}, 32'(ov[0]), 0);
  endtask

  initial begin
    exp_t e;
    int cyc, steps;
    reset = 1; step_en = 1; in_valid = 0; out_ready = 1; in_samples = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(ov[0]), 0);
    chk("rst_sample", 32'(os[0]), 0);
    chk("rst_busy", 32'(bz[0]), 0);
    chk("rst_ready", 32'(ir[0]), 1);
    reset = 0;
    @(negedge clk);
    txn("basic", 8'd100, 8'd40, 0);
    txn("negmax", 8'h80, 8'h80, 0);
    txn("unsigned", 8'd200, 8'd0, 0);
    txn("posmax", 8'd127, 8'd127, 0);
    txn("round64", 8'd64, 8'd0, 1);
    txn("round63", 8'd63, 8'd0, 0);
    txn("zero", 8'd0, 8'd0, 0);
    // result held while downstream stalls, then back-to-back accept on the handshake
    out_ready = 0;
    accept_txn("stall", 8'd10, 8'd20);
    wait_out("stall", 0, 0, cyc, steps);
    compare_out("stall", e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(ov[0]), 1);
      chk("hold_sample", 32'(os[0]), 32'(e[0]));
      chk("hold_ready", 32'(ir[0]), 0);
    end
    out_ready = 1;
    accept_txn("b2b", 8'hF6, 8'd55);
    chk("b2b_drop", 32'(ov[0]), 0);
    chk("b2b_busy", 32'(bz[0]), 1);
    wait_out("b2b", 0, 0, cyc, steps);
    chk("b2b_latency", 32'(cyc), 10);
    compare_out("b2b", e);
    @(negedge clk);
    accept_txn("sparse", 8'd100, 8'd40);
    wait_out("sparse", 0, 1, cyc, steps);
    chk("sparse_steps", 32'(steps), 8);
    chk("sparse_latency", 32'(cyc), 82);
    compare_out("sparse", e);
    @(negedge clk);
    accept_txn("rst_run", 8'd33, 8'd77);
    void'(sb.pop_front());
    repeat (4) @(negedge clk);
    chk("rst_run_busy", 32'(bz[0]), 1);
    reset = 1;
    @(negedge clk);
    chk("rst_run_valid", 32'(ov[0]), 0);
    chk("rst_run_ready", 32'(ir[0]), 1);
    chk("rst_run_idle", 32'(bz[0]), 0);
    reset = 0;
    txn("after_rst", 8'hC0, 8'd90, 0);
    out_ready = 0;
    accept_txn("rst_hold", 8'd50, 8'd50);
    wait_out("rst_hold", 0, 0, cyc, steps);
    compare_out("rst_hold", e);
    reset = 1;
    @(negedge clk);
    chk("rst_hold_valid", 32'(ov[0]), 0);
    chk("rst_hold_sample", 32'(os[0]), 0);
    reset = 0;
    out_ready = 1;
    txn("final", 8'd1, 8'hFF, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/da_fir_atom.md
Name: da_fir_atom

Overview:
- Parametrised bit-serial distributed-arithmetic (DA) multiply-accumulate atom for the upsampling interpolator chain.
- Computes y = sat(round(sum_i c_i*x_i / 2^FRAC)) over NTAPS input samples and NTAPS compile-time coefficients.
- Consumes one sample bit per enabled step and sequences itself internally; no external stage strobes.
- Sample exchange uses valid/ready handshakes, so several atoms can be chained or arbitrated per polyphase branch.

Parameters:
- DW, 8: sample width in bits.
- NTAPS, 2: taps per atom, legal range 1..4.
- CW, 8: signed coefficient width.
- COEFS, 0: packed NTAPS*CW vector of signed coefficients; tap i is at bits [i*CW +: CW].
- SIGNED_IN, 1: 1 = two's-complement samples; 0 = unsigned samples.
- FRAC, 7: number of fractional bits dropped at the output.
- OW, 8: signed output width.
- ROUND, 1: 1 = round half up (add 2^(FRAC-1) before shifting); 0 = truncate toward -inf.
- SAT, 1: 1 = saturate to the OW signed range; 0 = wrap (keep low OW bits).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- step_en  in  1  rate qualifier; a RUN step advances only when high.
- in_valid  in  1  input sample set valid.
- in_ready  out  1  atom can accept a sample set.
- in_samples  in  NTAPS*DW  packed samples; x_i is at bits [i*DW +: DW].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sample  out  OW  result, registered.
- busy  out  1  high while in RUN.

Behaviour:
- Reset: state IDLE; out_valid=0, out_sample=0, busy=0, in_ready=1; accumulator and shift registers cleared. Reset has priority over every other event.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, latch in_samples, clear accumulator, clear bit counter k, go to RUN.
  - RUN: in_ready=0, busy=1. Each cycle with step_en=1:
    - form P_k = sum of c_i over taps where bit k of x_i is 1;
    - add P_k*2^k to the accumulator;
    - if k=DW-1 and SIGNED_IN=1, subtract P_k*2^k instead of adding;
    - increment k.
    - When k=DW-1 is processed, go to FINAL.
    - Cycles with step_en=0 hold all state.
  - FINAL (one cycle, independent of step_en): apply rounding, shift by FRAC, and saturate or wrap. Register the result into out_sample, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1 and out_sample stable until out_ready=1.
    - On that handshake cycle in_ready=1 (pass-through of out_ready).
    - If in_valid is also high, the new set is accepted and the state goes directly to RUN (back-to-back). Otherwise go to IDLE.
    - out_valid drops the cycle after the handshake unless a new result is ready.
- Latency: with step_en=1 continuously, out_valid rises DW+2 cycles after the accept edge. Throughput is one result per DW+2 cycles when out_ready=1.
- Widths:
  - Accumulator AW = DW+CW+clog2(NTAPS)+1, signed, exact with no intermediate overflow.
  - Rounding addend is computed at AW width.
  - Saturation bounds are -2^(OW-1) and 2^(OW-1)-1.
  - FRAC=0 disables the rounding addend.
- Boundaries:
  - A coefficient of 0, or all-zero samples, gives 0.
  - x=-2^(DW-1) combined with a negative coefficient must not overflow AW.
  - in_valid while RUN/FINAL is ignored (not latched).
  - in_samples is sampled only on the accept cycle.
  - Reset mid-RUN or in HOLD discards the partial or pending result; out_valid falls on the next edge.

Decomposition:
- Package da_fir_pkg holds:
  - the state enum (IDLE, RUN, FINAL, HOLD);
  - a clog2 function;
  - an acc_width(DW,CW,NTAPS) function;
  - sat/round helper functions.
- One sub-module, da_partial_lut: combinational NTAPS-bit selector to the signed partial sum P, with coefficients as a parameter.
- Sequencing, accumulator and handshake stay in the top module.

Test Plan:
1. Setup DW=8, NTAPS=2, CW=8, FRAC=7, COEFS c0=64, c1=32, step_en=1. Drive x0=100, x1=40 -> out_sample=60. out_valid rises exactly 10 cycles after accept.
2. Same setup, x0=-128, x1=-128 -> -96. Same setup with SIGNED_IN=0, x0=200, x1=0 -> 100.
3. c0=c1=127, SAT=1: x=127,127 -> 127; x=-128,-128 -> -128. With SAT=0: x=127,127 -> acc 32258, then 252, which wraps to -4.
4. Rounding, c0=1, c1=0: x0=64 with ROUND=1 -> 1; x0=63 with ROUND=1 -> 0; x0=64 with ROUND=0 -> 0.
5. Flow control:
   - out_ready=0 for 5 cycles -> out_valid and out_sample held, in_ready=0.
   - Raise out_ready together with in_valid -> back-to-back accept, next result 10 cycles later.
   - step_en high only every 10th cycle -> same result value, out_valid after 8 enabled steps plus 2 cycles.
6. Assert reset at RUN step k=4 -> next cycle IDLE, out_valid=0, in_ready=1. The following transaction yields the correct value.
